ffram_dma: RTL and testbench

//  Command-driven initiator for the ffram word store: executes FILL, COPY and VERIFY

---
 rtl/ffram_dma.sv | 242 ++++++++++++++++++++++++
 tb/tb_ffram_dma.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffram_dma.sv
// ffram_dma: command-driven FILL / COPY / VERIFY initiator for one ffram word store.
// Drives the ffram port (wb_en/r_en/addr/d_in/bit_en) directly from registered state.
//
// Command handshake: start is a single-cycle strobe. It is accepted only when the
// block is idle (busy=0), and all operands are latched on the accepting edge. The
// block raises busy on the next cycle and keeps it high up to and including the
// one-cycle done pulse. err and the VERIFY results are valid with done and are held
// until the next accepted start. A start while busy is dropped without effect.
module ffram_dma #(
   parameter int WORD_NUM = 128,
   parameter int WORD_W   = 32,
   parameter int AD_WIDTH = $clog2(WORD_NUM),
   parameter int LEN_W    = $clog2(WORD_NUM) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [AD_WIDTH-1:0] src_addr,
   input  logic [AD_WIDTH-1:0] dst_addr,
   input  logic [LEN_W-1:0]    len,
   input  logic [WORD_W-1:0]   pattern,
   input  logic [WORD_W-1:0]   mask,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [LEN_W-1:0]    mismatch_cnt,
   output logic [AD_WIDTH-1:0] first_mis_addr,
   output logic                mem_wb_en,
   output logic                mem_r_en,
   output logic [AD_WIDTH-1:0] mem_addr,
   output logic [WORD_W-1:0]   mem_d_in,
   output logic [WORD_W-1:0]   mem_bit_en,
   input  logic [WORD_W-1:0]   mem_d_out,
   output logic [2:0]          dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_CP_RD = 3'd2,
      S_CP_WR = 3'd3,
      S_VER   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [1:0] OP_FILL = 2'b00;
   localparam logic [1:0] OP_COPY = 2'b01;
   localparam logic [1:0] OP_VER  = 2'b10;

   state_t              state_q, state_d;
   logic [AD_WIDTH-1:0] src_q, src_d;
   logic [AD_WIDTH-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [WORD_W-1:0]   pat_q, pat_d;
   logic [WORD_W-1:0]   mask_q, mask_d;
   logic [WORD_W-1:0]   buf_q, buf_d;
   logic                err_q, err_d;
   logic [LEN_W-1:0]    mis_cnt_q, mis_cnt_d;
   logic [AD_WIDTH-1:0] first_q, first_d;
   logic                ver_miss;

   // Address step with wrap at WORD_NUM-1, which need not be a power of two.
   function automatic logic [AD_WIDTH-1:0] wrap_inc(input logic [AD_WIDTH-1:0] a);
      if (a == AD_WIDTH'(WORD_NUM - 1)) return '0;
      else return a + AD_WIDTH'(1);
   endfunction

   // Masked compare of the word currently being read against the expected pattern.
   always_comb begin
      ver_miss = ((mem_d_out ^ pat_q) & mask_q) != '0;
   end

   // Next-state and next-value logic for the command sequencer.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      rem_d     = rem_q;
      pat_d     = pat_q;
      mask_d    = mask_q;
      buf_d     = buf_q;
      err_d     = err_q;
      mis_cnt_d = mis_cnt_q;
      first_d   = first_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d     = src_addr;
               dst_d     = dst_addr;
               rem_d     = len;
               pat_d     = pattern;
               mask_d    = mask;
               mis_cnt_d = '0;
               first_d   = '0;
               err_d     = 1'b0;
               if (len == '0) begin
                  state_d = S_DONE;
               end else if (op == 2'b11 || len > LEN_W'(WORD_NUM)) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else if (op == OP_FILL) begin
                  state_d = S_FILL;
               end else if (op == OP_COPY) begin
                  state_d = S_CP_RD;
               end else if (op == OP_VER) begin
                  state_d = S_VER;
               end
            end
         end
         S_FILL: begin
            dst_d = wrap_inc(dst_q);
            rem_d = rem_q - LEN_W'(1);
            if (abort) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (rem_q == LEN_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_CP_RD: begin
            buf_d = mem_d_out;
            if (abort) begin
               // The word just read is dropped: nothing is written for it.
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               state_d = S_CP_WR;
            end
         end
         S_CP_WR: begin
            src_d = wrap_inc(src_q);
            dst_d = wrap_inc(dst_q);
            rem_d = rem_q - LEN_W'(1);
            if (abort) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (rem_q == LEN_W'(1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CP_RD;
            end
         end
         S_VER: begin
            src_d = wrap_inc(src_q);
            rem_d = rem_q - LEN_W'(1);
            // The read presented this cycle completes, so it is scored even on abort.
            if (ver_miss) begin
               mis_cnt_d = mis_cnt_q + LEN_W'(1);
               if (mis_cnt_q == '0) first_d = src_q;
            end
            if (abort) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (rem_q == LEN_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset returns everything to idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
         pat_q     <= '0;
         mask_q    <= '0;
         buf_q     <= '0;
         err_q     <= 1'b0;
         mis_cnt_q <= '0;
         first_q   <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         rem_q     <= rem_d;
         pat_q     <= pat_d;
         mask_q    <= mask_d;
         buf_q     <= buf_d;
         err_q     <= err_d;
         mis_cnt_q <= mis_cnt_d;
         first_q   <= first_d;
      end
   end

   // Memory port decode from registered state; idle and done present no access.
   always_comb begin
      mem_wb_en  = 1'b0;
      mem_r_en   = 1'b0;
      mem_addr   = '0;
      mem_d_in   = '0;
      mem_bit_en = '0;
      case (state_q)
         S_FILL: begin
            mem_wb_en  = 1'b1;
            mem_addr   = dst_q;
            mem_d_in   = pat_q;
            mem_bit_en = mask_q;
         end
         S_CP_RD: begin
            mem_wb_en = 1'b1;
            mem_r_en  = 1'b1;
            mem_addr  = src_q;
         end
         S_CP_WR: begin
            mem_wb_en  = 1'b1;
            mem_addr   = dst_q;
            mem_d_in   = buf_q;
            mem_bit_en = mask_q;
         end
         S_VER: begin
            mem_wb_en = 1'b1;
            mem_r_en  = 1'b1;
            mem_addr  = src_q;
         end
         default: begin
            mem_wb_en = 1'b0;
         end
      endcase
   end

   // Status outputs decoded from registered state.
   always_comb begin
      busy           = (state_q != S_IDLE);
      done           = (state_q == S_DONE);
      err            = err_q;
      mismatch_cnt   = mis_cnt_q;
      first_mis_addr = first_q;
      dbg_state      = state_q;
   end

endmodule

// File: tb/tb_ffram_dma.sv
// tb_ffram_dma: randomized and directed bench for ffram_dma with a behavioural
// ffram stand-in, an expected-write queue and a command-level reference model.
module tb_ffram_dma;
   localparam int WN = 128;
   localparam int WW = 32;
   localparam int AW = 7;
   localparam int LW = 8;

   logic          clk, rst, start, abort;
   logic [1:0]    op;
   logic [AW-1:0] src_addr, dst_addr;
   logic [LW-1:0] len;
   logic [WW-1:0] pattern, mask;
   logic          busy, done, err;
   logic [LW-1:0] mismatch_cnt;
   logic [AW-1:0] first_mis_addr;
   logic          mem_wb_en, mem_r_en;
   logic [AW-1:0] mem_addr;
   logic [WW-1:0] mem_d_in, mem_bit_en, mem_d_out;
   logic [2:0]    dbg_state;

   // ffram stand-in and the bench's own view of what it should contain
   logic [WW-1:0] fmem [WN];
   logic [WW-1:0] ref_mem [WN];
   logic          mem_clr, poke_en;
   logic [AW-1:0] poke_addr;
   logic [WW-1:0] poke_data;

   logic [AW+WW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass = 0;
   int acc_cnt = 0;
   int wr_bad = 0;

   ffram_dma #(.WORD_NUM(WN), .WORD_W(WW)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .pattern(pattern), .mask(mask), .abort(abort),
      .busy(busy), .done(done), .err(err),
      .mismatch_cnt(mismatch_cnt), .first_mis_addr(first_mis_addr),
      .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
      .mem_d_in(mem_d_in), .mem_bit_en(mem_bit_en), .mem_d_out(mem_d_out),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ffram behaviour: combinational read, masked write (bit_en & d_in) at the edge
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < WN; i++) fmem[i] <= '0;
      end else if (poke_en) begin
         fmem[poke_addr] <= poke_data;
      end else if (mem_wb_en && !mem_r_en) begin
         fmem[mem_addr] <= mem_d_in & mem_bit_en;
      end
   end
   assign mem_d_out = fmem[mem_addr];

   // write monitor: every write presented must match the head of exp_q
   always @(negedge clk) begin
      logic [AW+WW-1:0] e;
      if (mem_wb_en) acc_cnt++;
      if (mem_wb_en && !mem_r_en) begin
         if (exp_q.size() == 0) begin
            wr_bad++;
            $display("  unexpected write addr=%0d data=%h", mem_addr, mem_d_in & mem_bit_en);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_d_in & mem_bit_en} !== e) begin
              wr_bad++;
              $display("  write got addr=%0d data=%h want addr=%0d data=%h",
                       mem_addr, mem_d_in & mem_bit_en, e[AW+WW-1:WW], e[WW-1:0]);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int mem_diff();
      int d = 0;
      for (int i = 0; i < WN; i++) if (fmem[i] !== ref_mem[i]) d++;
      return d;
   endfunction

   task automatic poke(input int a, input logic [WW-1:0] v);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = AW'(a); poke_data = v;
      @(negedge clk);
      poke_en = 1'b0;
      ref_mem[a] = v;
   endtask

   // Reference model: outcome of one command from the command rules alone.
   // stop_words < 0 means no truncation (used to model a reset mid-command).
   task automatic model_cmd(input logic [1:0] o, input int s, input int d, input int l,
                            input logic [WW-1:0] p, input logic [WW-1:0] m,
                            input int abort_at, input int stop_words,
                            output int e_cyc, output bit e_err, output int e_mis,
                            output int e_first, output int e_acc);
      int nacc, words, a;
      logic [WW-1:0] v;
      e_mis = 0; e_first = 0; e_err = 0; e_acc = 0;
      if (l == 0) begin e_cyc = 1; return; end
      if (o == 2'b11 || l > WN) begin e_cyc = 1; e_err = 1; return; end
      nacc  = (o == 2'b01) ? 2 * l : l;
      words = l;
      if (abort_at >= 1 && abort_at <= nacc) begin
         e_err = 1; e_cyc = abort_at + 1;
         words = (o == 2'b01) ? abort_at / 2 : abort_at;
      end else begin
         e_cyc = nacc + 1;
      end
      e_acc = e_cyc - 1;
      if (stop_words >= 0 && stop_words < words) words = stop_words;
      for (int i = 0; i < words; i++) begin
         case (o)
            2'b00: begin
               a = (d + i) % WN;
               exp_q.push_back({AW'(a), p & m});
               ref_mem[a] = p & m;
            end
            2'b01: begin
               v = ref_mem[(s + i) % WN] & m;
               a = (d + i) % WN;
               exp_q.push_back({AW'(a), v});
               ref_mem[a] = v;
            end
            default: begin
               a = (s + i) % WN;
               if ((ref_mem[a] & m) != (p & m)) begin
                  if (e_mis == 0) e_first = a;
                  e_mis++;
               end
            end
         endcase
      end
   endtask

   int acc_base, bad_base;

   // driver: present a command for one edge, then scramble the operand inputs
   task automatic issue(input logic [1:0] o, input int s, input int d, input int l,
                        input logic [WW-1:0] p, input logic [WW-1:0] m);
      @(negedge clk);
      op = o; src_addr = AW'(s); dst_addr = AW'(d); len = LW'(l);
      pattern = p; mask = m; start = 1'b1;
      acc_base = acc_cnt; bad_base = wr_bad;
      @(posedge clk);
      #1;
      start = 1'b0;
      op = 2'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
      len = LW'($urandom); pattern = $urandom; mask = $urandom;
   endtask

   task automatic finish_cmd(input string tag, input int abort_at, input int e_cyc,
                             input bit e_err, input int e_mis, input int e_first,
                             input int e_acc);
      int cyc = 0;
      bit seen = 0;
      bit busy_low = 0;
      while (!seen && cyc < 400) begin
         @(negedge clk);
         cyc++;
         abort = (cyc == abort_at);
         if (done) seen = 1;
         else if (!busy) busy_low = 1;
      end
      chk({tag, "_done_cycle"}, seen ? cyc : -1, e_cyc);
      chk({tag, "_busy_gap"}, busy_low, 0);
      chk({tag, "_busy_at_done"}, busy, 1);
      chk({tag, "_err"}, err, e_err);
      chk({tag, "_mis_cnt"}, mismatch_cnt, e_mis);
      chk({tag, "_first_mis"}, first_mis_addr, e_first);
      @(negedge clk);
      abort = 1'b0;
      chk({tag, "_done_pulse"}, {done, busy}, 2'b00);
      chk({tag, "_err_held"}, err, e_err);
      chk({tag, "_accesses"}, acc_cnt - acc_base, e_acc);
      chk({tag, "_bad_writes"}, wr_bad - bad_base, 0);
      chk({tag, "_missing_writes"}, exp_q.size(), 0);
      chk({tag, "_mem_image"}, mem_diff(), 0);
      exp_q.delete();
   endtask

   task automatic run(input string tag, input logic [1:0] o, input int s, input int d,
                      input int l, input logic [WW-1:0] p, input logic [WW-1:0] m,
                      input int abort_at);
      int e_cyc, e_mis, e_first, e_acc;
      bit e_err;
      model_cmd(o, s, d, l, p, m, abort_at, -1, e_cyc, e_err, e_mis, e_first, e_acc);
      issue(o, s, d, l, p, m);
      finish_cmd(tag, abort_at, e_cyc, e_err, e_mis, e_first, e_acc);
   endtask

   initial begin
      int e_cyc, e_mis, e_first, e_acc, r, l, s, d, ab, nacc;
      bit e_err;
      logic [1:0] o;
      logic [WW-1:0] p, m;

      rst = 1'b1; start = 1'b0; abort = 1'b0; op = '0; src_addr = '0; dst_addr = '0;
      len = '0; pattern = '0; mask = '0; mem_clr = 1'b1; poke_en = 1'b0;
      poke_addr = '0; poke_data = '0;
      for (int i = 0; i < WN; i++) ref_mem[i] = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_mis_cnt", mismatch_cnt, 0);
      chk("rst_first_mis", first_mis_addr, 0);
      chk("rst_mem_ctl", {mem_wb_en, mem_r_en, mem_addr}, 0);
      chk("rst_mem_data", {mem_d_in, mem_bit_en}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0; mem_clr = 1'b0;

      // FILL across the wrap point
      run("fill_wrap", 2'b00, 0, 120, 10, 32'hA5A5A5A5, 32'hFFFFFFFF, 0);

      // COPY 0..3 -> 64..67
      for (int i = 0; i < 4; i++) poke(i, WW'(i + 1));
      run("copy_basic", 2'b01, 0, 64, 4, 0, 32'hFFFFFFFF, 0);
      chk("copy_word67", fmem[67], 4);

      // VERIFY with two mismatches
      poke(10, 0); poke(11, 0); poke(12, 1); poke(13, 0); poke(14, 32'hF0);
      run("ver_two", 2'b10, 10, 0, 5, 0, 32'hFFFFFFFF, 0);
      chk("ver_two_spec_cnt", mismatch_cnt, 2);
      chk("ver_two_spec_first", first_mis_addr, 12);

      // VERIFY where the only differing bits are masked off
      poke(30, 32'h12340000);
      run("ver_masked", 2'b10, 30, 0, 1, 0, 32'h0000FFFF, 0);

      // zero length, reserved op, oversize length, full length
      run("len_zero", 2'b00, 0, 5, 0, 32'hDEADBEEF, 32'hFFFFFFFF, 0);
      run("op_rsvd", 2'b11, 0, 5, 4, 32'hDEADBEEF, 32'hFFFFFFFF, 0);
      run("len_over", 2'b00, 0, 5, WN + 1, 32'hDEADBEEF, 32'hFFFFFFFF, 0);
      run("fill_full", 2'b00, 77, 77, WN, 32'h3C3C00FF, 32'h0F0FFFF0, 0);

      // abort three cycles into a FILL; abort in a COPY read cycle
      run("fill_abort", 2'b00, 0, 40, 20, 32'h11112222, 32'hFFFFFFFF, 3);
      run("copy_abort_rd", 2'b01, 40, 90, 8, 0, 32'hFFFFFFFF, 5);

      // overlapping forward copy propagates already-copied data
      run("copy_overlap", 2'b01, 40, 41, 6, 0, 32'hFFFFFFFF, 0);

      // reset in the middle of a COPY (during the third word's read)
      for (int i = 0; i < 6; i++) poke(i, $urandom);
      model_cmd(2'b01, 0, 50, 6, 0, 32'hFFFFFFFF, 0, 2, e_cyc, e_err, e_mis, e_first, e_acc);
      issue(2'b01, 0, 50, 6, 0, 32'hFFFFFFFF);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_wb_en", mem_wb_en, 0);
      chk("rst_mid_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_accesses", acc_cnt - acc_base, 5);
      chk("rst_mid_missing_writes", exp_q.size(), 0);
      chk("rst_mid_mem_image", mem_diff(), 0);
      chk("rst_mid_err", err, 0);
      exp_q.delete();

      // randomized commands
      for (int n = 0; n < 24; n++) begin
         r = $urandom_range(0, 9);
         o = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         r = $urandom_range(0, 9);
         l = (r == 0) ? 0 : (r == 1) ? WN : (r == 2) ? WN + 1 + $urandom_range(0, 5)
                                           : $urandom_range(1, 24);
         s = $urandom_range(0, WN - 1);
         d = $urandom_range(0, WN - 1);
         m = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
         p = $urandom;
         if (o == 2'b10 && $urandom_range(0, 1) == 1) p = ref_mem[s];
         ab = 0;
         if (o != 2'b10 && o != 2'b11 && l >= 1 && l <= WN && $urandom_range(0, 3) == 0) begin
            nacc = (o == 2'b01) ? 2 * l : l;
            ab = $urandom_range(1, nacc);
         end
         run($sformatf("rand%0d", n), o, s, d, l, p, m, ab);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
